// File: rtl/elixirchip_es1_spu_op_reg_bank_if.sv
// ---------------------------------------------------------------------------
// elixirchip_es1_spu_op_reg_bank_if
//
// Bus bundle for the multi-channel SPU register bank. It carries both the
// upstream (s_*) and downstream (m_*) sides, so one instance wires a bank
// into the SPU datapath.
//
// Parameters
//   CHANNELS   number of channels (must match the attached bank)
//   DATA_BITS  data width per channel (must match the attached bank)
//
// Signals
//   s_data     [CHANNELS][DATA_BITS]  input data per channel
//   s_clear    [CHANNELS]             per-channel clear
//   s_valid    [CHANNELS]             per-channel input valid
//   m_data     [CHANNELS][DATA_BITS]  output data per channel
//   m_valid    [CHANNELS]             output update strobe per channel
//   m_changed  [CHANNELS]             output-changed flag, only when
//                                     ELIXIRCHIP_ES1_SPU_OP_REG_BANK_CHANGED_EN
//                                     is defined
//
// Modports
//   master  upstream/downstream neighbour: drives s_*, observes m_*
//   slave   the register bank: observes s_*, drives m_*
// ---------------------------------------------------------------------------
interface elixirchip_es1_spu_op_reg_bank_if #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned DATA_BITS = 8
);

  logic [CHANNELS-1:0][DATA_BITS-1:0] s_data;
  logic [CHANNELS-1:0]                s_clear;
  logic [CHANNELS-1:0]                s_valid;
  logic [CHANNELS-1:0][DATA_BITS-1:0] m_data;
  logic [CHANNELS-1:0]                m_valid;
`ifdef ELIXIRCHIP_ES1_SPU_OP_REG_BANK_CHANGED_EN
  logic [CHANNELS-1:0]                m_changed;
`endif

`ifdef ELIXIRCHIP_ES1_SPU_OP_REG_BANK_CHANGED_EN
  modport master (
    output s_data, s_clear, s_valid,
    input  m_data, m_valid, m_changed
  );

  modport slave (
    input  s_data, s_clear, s_valid,
    output m_data, m_valid, m_changed
  );
`else
  modport master (
    output s_data, s_clear, s_valid,
    input  m_data, m_valid
  );

  modport slave (
    input  s_data, s_clear, s_valid,
    output m_data, m_valid
  );
`endif

endinterface

// File: rtl/elixirchip_es1_spu_op_reg_bank.sv
// ---------------------------------------------------------------------------
// elixirchip_es1_spu_op_reg_bank
//
// Multi-channel SPU register op. CHANNELS independent registers share one
// clk/cke. Each channel captures s_data on s_valid, or loads CLEAR_DATA on
// s_clear (clear wins), and presents the result through a valid-qualified
// delay line LATENCY enabled cycles deep. A clear counts as an update and
// raises m_valid like a write.
//
// Optional feature macro: ELIXIRCHIP_ES1_SPU_OP_REG_BANK_CHANGED_EN
//   defined   -> bus.m_changed is present: a registered per-channel flag,
//                aligned to m_valid, set when the new m_data differs from
//                the previous m_data.
//   undefined -> m_changed and its logic are absent.
//
// Parameters
//   CHANNELS    number of independent channels (>= 1)
//   LATENCY     s_* to m_* latency in enabled cycles (>= 1)
//   DATA_BITS   data width per channel
//   data_t      per-channel data type (DATA_BITS wide)
//   CLEAR_DATA  value loaded by clear and by reset
//   DEVICE      target device string
//   SIMULATION  "true"/"false" build switch
//   DEBUG       "true"/"false" build switch
//
// Ports
//   reset  in   asynchronous reset, active-high
//   clk    in   clock
//   cke    in   clock enable; when 0 every register (and so every output)
//               holds
//   bus    slave modport of elixirchip_es1_spu_op_reg_bank_if
//            s_data/s_clear/s_valid  per-channel inputs
//            m_data/m_valid          per-channel outputs
//            m_changed               per-channel change flag (macro only)
// ---------------------------------------------------------------------------
module elixirchip_es1_spu_op_reg_bank #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned DATA_BITS  = 8,
  parameter type         data_t     = logic [DATA_BITS-1:0],
  parameter data_t       CLEAR_DATA = '0,
  parameter string       DEVICE     = "RTL",
  parameter string       SIMULATION = "false",
  parameter string       DEBUG      = "false"
) (
  input  logic                             reset,
  input  logic                             clk,
  input  logic                             cke,
  elixirchip_es1_spu_op_reg_bank_if.slave  bus
);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // -------------------------------------------------------------------------
  if (CHANNELS < 1) begin : g_bad_channels
    $error("elixirchip_es1_spu_op_reg_bank: CHANNELS must be >= 1");
  end

  if (LATENCY < 1) begin : g_bad_latency
    $error("elixirchip_es1_spu_op_reg_bank: LATENCY must be >= 1");
  end

  if ($bits(data_t) != DATA_BITS) begin : g_bad_data_t
    $error("elixirchip_es1_spu_op_reg_bank: data_t width must equal DATA_BITS");
  end

  if (DEVICE == "") begin : g_bad_device
    $error("elixirchip_es1_spu_op_reg_bank: DEVICE must not be empty");
  end

  if (SIMULATION != "true" && SIMULATION != "false") begin : g_bad_simulation
    $error("elixirchip_es1_spu_op_reg_bank: SIMULATION must be \"true\" or \"false\"");
  end

  if (DEBUG != "true" && DEBUG != "false") begin : g_bad_debug
    $error("elixirchip_es1_spu_op_reg_bank: DEBUG must be \"true\" or \"false\"");
  end

  // -------------------------------------------------------------------------
  // Per-channel datapath
  // -------------------------------------------------------------------------
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch

    // One register pair per stage; stage 0 is the capture register, the
    // last stage drives the outputs.
    for (genvar k = 0; k < LATENCY; k++) begin : g_stg
      data_t data_q;
      data_t data_d;
      logic  valid_q;
      logic  valid_d;

      if (k == 0) begin : g_in
        always_comb begin
          valid_d = bus.s_clear[ch] | bus.s_valid[ch];
          data_d  = data_q;
          if (bus.s_clear[ch]) begin
            data_d = CLEAR_DATA;
          end else if (bus.s_valid[ch]) begin
            data_d = data_t'(bus.s_data[ch]);
          end
        end
      end else begin : g_dly
        // Data only moves with its valid, so a stage keeps showing the last
        // delivered value while bubbles pass through.
        always_comb begin
          valid_d = g_stg[k-1].valid_q;
          data_d  = data_q;
          if (g_stg[k-1].valid_q) begin
            data_d = g_stg[k-1].data_q;
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_q  <= CLEAR_DATA;
          valid_q <= 1'b0;
        end else if (cke) begin
          data_q  <= data_d;
          valid_q <= valid_d;
        end
      end
    end

    assign bus.m_data[ch]  = g_stg[LATENCY-1].data_q;
    assign bus.m_valid[ch] = g_stg[LATENCY-1].valid_q;

`ifdef ELIXIRCHIP_ES1_SPU_OP_REG_BANK_CHANGED_EN
    // Compare the value about to be presented against the one currently on
    // m_data, so the flag lands in the same cycle as its m_valid.
    logic changed_q;
    logic changed_d;

    always_comb begin
      changed_d = g_stg[LATENCY-1].valid_d &&
                  (g_stg[LATENCY-1].data_d != g_stg[LATENCY-1].data_q);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        changed_q <= 1'b0;
      end else if (cke) begin
        changed_q <= changed_d;
      end
    end

    assign bus.m_changed[ch] = changed_q;
`endif

  end

endmodule

// File: tb/tb_elixirchip_es1_spu_op_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_elixirchip_es1_spu_op_reg_bank
//
// Directed bench for the SPU register bank. Two instances:
//   dut_a  LATENCY=3, CLEAR_DATA=0x00  (reset, latency, clear, burst, changed)
//   dut_b  LATENCY=2, CLEAR_DATA=0xC3  (cke stall, non-zero clear value)
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_elixirchip_es1_spu_op_reg_bank;

  logic clk;
  logic rst;
  logic cke_a;
  logic cke_b;

  int unsigned checks;
  int unsigned errors;

  elixirchip_es1_spu_op_reg_bank_if #(.CHANNELS(4), .DATA_BITS(8)) bus_a ();
  elixirchip_es1_spu_op_reg_bank_if #(.CHANNELS(4), .DATA_BITS(8)) bus_b ();

  elixirchip_es1_spu_op_reg_bank #(
    .CHANNELS   (4),
    .LATENCY    (3),
    .DATA_BITS  (8),
    .CLEAR_DATA (8'h00)
  ) dut_a (
    .reset (rst),
    .clk   (clk),
    .cke   (cke_a),
    .bus   (bus_a)
  );

  elixirchip_es1_spu_op_reg_bank #(
    .CHANNELS   (4),
    .LATENCY    (2),
    .DATA_BITS  (8),
    .CLEAR_DATA (8'hC3)
  ) dut_b (
    .reset (rst),
    .clk   (clk),
    .cke   (cke_b),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.s_data  = '0;
    bus_a.s_clear = '0;
    bus_a.s_valid = '0;
  endtask

  task automatic idle_b();
    bus_b.s_data  = '0;
    bus_b.s_clear = '0;
    bus_b.s_valid = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    cke_a  = 1'b1;
    cke_b  = 1'b1;
    idle_a();
    idle_b();

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_a_valid", {28'd0, bus_a.m_valid}, 32'h0);
    check("rst_a_data",  bus_a.m_data,           32'h0000_0000);
    check("rst_b_valid", {28'd0, bus_b.m_valid}, 32'h0);
    check("rst_b_data",  bus_b.m_data,           32'hC3C3_C3C3);
`ifdef ELIXIRCHIP_ES1_SPU_OP_REG_BANK_CHANGED_EN
    check("rst_a_changed", {28'd0, bus_a.m_changed}, 32'h0);
`endif
    rst = 1'b0;
    tick();

    // ---------------- reset mid-stream ----------------
    bus_a.s_valid[0] = 1'b1;
    bus_a.s_data[0]  = 8'h5A;
    tick();
    idle_a();
    rst = 1'b1;
    #1;
    check("midrst_valid", {28'd0, bus_a.m_valid}, 32'h0);
    check("midrst_data",  bus_a.m_data,           32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_after_valid", {28'd0, bus_a.m_valid}, 32'h0);
      check("midrst_after_data",  bus_a.m_data,           32'h0);
    end

    // ---------------- latency 3 on ch1 ----------------
    bus_a.s_valid[1] = 1'b1;
    bus_a.s_data[1]  = 8'hA5;
    tick();
    idle_a();
    check("lat_t1_valid", {28'd0, bus_a.m_valid}, 32'h0);
    tick();
    check("lat_t2_valid", {28'd0, bus_a.m_valid}, 32'h0);
    check("lat_t2_data",  bus_a.m_data,           32'h0);
    tick();
    check("lat_t3_valid", {28'd0, bus_a.m_valid}, 32'h2);
    check("lat_t3_data",  bus_a.m_data,           32'h0000_A500);
    tick();
    check("lat_t4_valid", {28'd0, bus_a.m_valid}, 32'h0);
    check("lat_t4_data",  bus_a.m_data,           32'h0000_A500);

    // ---------------- clear priority on ch2 ----------------
    bus_a.s_valid[2] = 1'b1;
    bus_a.s_data[2]  = 8'h77;
    tick();
    bus_a.s_clear[2] = 1'b1;
    bus_a.s_valid[2] = 1'b1;
    bus_a.s_data[2]  = 8'h33;
    tick();
    idle_a();
    tick();
    check("clr_w_valid", {28'd0, bus_a.m_valid}, 32'h4);
    check("clr_w_data",  bus_a.m_data,           32'h0077_A500);
    tick();
    check("clr_c_valid", {28'd0, bus_a.m_valid}, 32'h4);
    check("clr_c_data",  bus_a.m_data,           32'h0000_A500);
    tick();
    check("clr_idle_valid", {28'd0, bus_a.m_valid}, 32'h0);

    // ---------------- burst on ch3 with a concurrent ch0 write ----------------
    begin
      logic [31:0] exp_data [7];
      logic [3:0]  exp_vld  [7];
      exp_data = '{32'h0000_A500, 32'h0000_A500, 32'h0100_A53C, 32'h0200_A53C,
                   32'h0300_A53C, 32'h0400_A53C, 32'h0400_A53C};
      exp_vld  = '{4'h0, 4'h0, 4'h9, 4'h8, 4'h8, 4'h8, 4'h0};
      for (int c = 0; c < 7; c++) begin
        idle_a();
        if (c < 4) begin
          bus_a.s_valid[3] = 1'b1;
          bus_a.s_data[3]  = 8'(c + 1);
        end
        if (c == 0) begin
          bus_a.s_valid[0] = 1'b1;
          bus_a.s_data[0]  = 8'h3C;
        end
        tick();
        check("burst_valid", {28'd0, bus_a.m_valid}, {28'd0, exp_vld[c]});
        check("burst_data",  bus_a.m_data,           exp_data[c]);
      end
      idle_a();
    end

    // ---------------- cke stall on dut_b ----------------
    bus_b.s_valid[0] = 1'b1;
    bus_b.s_data[0]  = 8'h11;
    tick();
    idle_b();
    cke_b = 1'b0;
    bus_b.s_valid[1] = 1'b1;
    bus_b.s_data[1]  = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", {28'd0, bus_b.m_valid}, 32'h0);
      check("stall_data",  bus_b.m_data,           32'hC3C3_C3C3);
    end
    idle_b();
    cke_b = 1'b1;
    tick();
    check("stall_out_valid", {28'd0, bus_b.m_valid}, 32'h1);
    check("stall_out_data",  bus_b.m_data,           32'hC3C3_C311);
    cke_b = 1'b0;
    tick();
    tick();
    check("freeze_hi_valid", {28'd0, bus_b.m_valid}, 32'h1);
    check("freeze_hi_data",  bus_b.m_data,           32'hC3C3_C311);
    cke_b = 1'b1;
    tick();
    check("unfreeze_valid", {28'd0, bus_b.m_valid}, 32'h0);
    check("unfreeze_data",  bus_b.m_data,           32'hC3C3_C311);

    // ---------------- clear to non-zero CLEAR_DATA on dut_b ch3 ----------------
    bus_b.s_valid[3] = 1'b1;
    bus_b.s_data[3]  = 8'h05;
    tick();
    bus_b.s_valid[3] = 1'b0;
    bus_b.s_clear[3] = 1'b1;
    tick();
    idle_b();
    check("b_clr_w_data", bus_b.m_data, 32'h05C3_C311);
    tick();
    check("b_clr_c_valid", {28'd0, bus_b.m_valid}, 32'h8);
    check("b_clr_c_data",  bus_b.m_data,           32'hC3C3_C311);

`ifdef ELIXIRCHIP_ES1_SPU_OP_REG_BANK_CHANGED_EN
    // ---------------- change flag on dut_a ch0 (ch0 holds 0x3C) ----------------
    begin
      logic [31:0] exp_d [6];
      logic [3:0]  exp_c [6];
      exp_d = '{32'h0400_A53C, 32'h0400_A53C, 32'h0400_A507, 32'h0400_A507,
                32'h0400_A500, 32'h0400_A500};
      exp_c = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0};
      for (int c = 0; c < 6; c++) begin
        idle_a();
        if (c < 2) begin
          bus_a.s_valid[0] = 1'b1;
          bus_a.s_data[0]  = 8'h07;
        end
        if (c == 2) begin
          bus_a.s_clear[0] = 1'b1;
        end
        tick();
        check("chg_data", bus_a.m_data,                 exp_d[c]);
        check("chg_flag", {28'd0, bus_a.m_changed},     {28'd0, exp_c[c]});
      end
      idle_a();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
